apb2axi: RTL and testbench
==========================

// Module: apb2axi
// PURPOSE
//  APB3 completer to AXI4-Lite manager bridge; the reverse of the MMIO AXI->APB bridge.
//  Lets an APB-side requester (debug/boot loader) reach the AXI-Lite code/data RAMs in the SoC.
//  Exactly one outstanding transaction. Each APB access becomes one AXI-Lite read or write.
//  APB pready is held low until the AXI response returns.
// PARAMETERS
//  ADDR_W          32    APB/AXI address width
//  DATA_W          32    data width (fixed 32 in this SoC)
//  AXI_PROT        3'b000 constant driven on awprot/arprot
//  TIMEOUT_CYCLES  256   response timeout; used only with APB2AXI_TIMEOUT_EN
// PORTS
//  clk      in  1       clock
//  rst_n    in  1       asynchronous active-low reset
//  paddr    in  ADDR_W  APB address
//  psel, penable, pwrite  in 1 each  APB control
//  pwdata   in  DATA_W  APB write data
//  prdata   out DATA_W  APB read data (registered)
//  pready   out 1       APB completion, one-cycle pulse
//  pslverr  out 1       APB error, valid with pready
//  aw{valid,addr,prot}  out 1/ADDR_W/3 ; awready in 1
//  w{valid,data,strb}   out 1/DATA_W/DATA_W/8 ; wready in 1
//  bvalid in 1 ; bresp in 2 ; bready out 1
//  ar{valid,addr,prot}  out 1/ADDR_W/3 ; arready in 1
//  rvalid in 1 ; rdata in DATA_W ; rresp in 2 ; rready out 1
// BEHAVIOUR
//  Reset: all valids/readies 0, pready 0, pslverr 0, prdata 0, FSM=IDLE. Reset mid-transfer abandons it.
//  IDLE: psel&~penable (setup) captures paddr/pwdata/pwrite; go to AR if read, else WREQ.
//  AR: arvalid=1, araddr=captured; hold until arready -> RD.
//  RD: rready=1; on rvalid latch rdata into prdata, err=rresp[1] -> DONE.
//  WREQ: awvalid and wvalid both asserted; each drops independently on its own handshake.
//    wstrb='1. Leave when both are done (same or different cycles) -> WR.
//  WR: bready=1; on bvalid err=bresp[1] -> DONE.
//  DONE: pready=1, pslverr=err for exactly one cycle -> IDLE. A new setup is accepted the next cycle.
//  Best-case latency with zero-wait slaves: read = setup + 3 cycles to pready. Write is the same.
//  No AXI signal changes while valid&~ready (AXI stability rule).
//  prdata is held after DONE until the next read completes. Writes never modify prdata.
//  psel dropped mid-transfer is an APB violation. The AXI transfer still completes and pready still pulses.
//  Any response with resp[1]=1 (SLVERR/DECERR) -> pslverr=1. EXOKAY is not expected and is treated as OKAY.
// CONFIGURATION
//  APB2AXI_TIMEOUT_EN defined:
//    - A counter starts when the FSM leaves IDLE.
//    - If the response has not arrived after TIMEOUT_CYCLES cycles: DONE with pslverr=1, prdata=32'hDEAD_BEEF.
//    - The FSM then enters DRAIN, keeping the pending valids and holding rready/bready=1 until the
//      outstanding handshakes and response complete. Only then does it return to IDLE.
//    - A new setup arriving during DRAIN is captured and waits; its pready is delayed accordingly.
//  APB2AXI_TIMEOUT_EN undefined: no counter and no DRAIN state; the bridge waits indefinitely.
// STRUCTURE
//  apb2axi_pkg:
//    - state_e enum {IDLE, AR, RD, WREQ, WR, DONE, DRAIN}
//    - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
//    - TIMEOUT_DATA=32'hDEAD_BEEF
//  Sub-module apb2axi_timeout (start/clear/expired; counter width $clog2(TIMEOUT_CYCLES+1)),
//  instantiated only under APB2AXI_TIMEOUT_EN.
//  The top holds the FSM and the capture registers. Ports are flat wires so the block can be bound to the
//  axi/apb interfaces at SoC level.
// TESTING
//  1 Read 0x0000_0010; slave arready=1, returns rdata=0x1234_5678/OKAY with 0 wait
//    -> araddr=0x10, prdata=0x1234_5678, pready at setup+3, pslverr=0.
//  2 Write 0x0000_0020 data 0xA5A5_0001; awready 2 cycles before wready
//    -> one AW and one W handshake each, wstrb=4'hF, pready 1 cycle after bvalid.
//  3 Read returns rresp=2'b10 -> pready=1 with pslverr=1. Write returns bresp=2'b11 -> pslverr=1.
//  4 Hold arready=0 for 10 cycles -> arvalid/araddr stable all 10 cycles, pready stays 0 throughout.
//  5 Assert rst_n=0 while in RD -> all outputs 0 within the reset cycle. The next read after release completes normally.
//  6 (APB2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16) Slave never answers a read:
//    -> pready+pslverr at cycle 16, prdata=0xDEAD_BEEF.
//    Late rvalid at cycle 40 is absorbed. A second read queued in DRAIN completes after it.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB3 -> AXI4-Lite bridge.
// The bridge FSM encoding, the AXI response codes and the timeout read-data pattern live here.
package apb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    RD,
    WREQ,
    WR,
    DONE,
    DRAIN
  } state_e;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // EXOKAY (2'b01) is deliberately folded into the non-error case.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/apb2axi_timeout.sv
// Response watchdog: start loads 1 so expired rises in the (TIMEOUT_CYCLES-1)th cycle after start,
// letting the bridge register DONE in cycle TIMEOUT_CYCLES. Only built with APB2AXI_TIMEOUT_EN.
module apb2axi_timeout
  import apb2axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          run;

  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= CW'(1);
      run <= 1'b1;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apb2axi.sv
// APB3 completer -> AXI4-Lite manager, one outstanding access; pready at setup+3 with zero-wait slaves.
// pready stays low until the AXI response returns; APB2AXI_TIMEOUT_EN adds a response timeout with drain.
module apb2axi
  import apb2axi_pkg::*;
#(
  parameter int         ADDR_W         = 32,
  parameter int         DATA_W         = 32,
  parameter logic [2:0] AXI_PROT       = 3'b000,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                awvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  input  logic                awready,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                arvalid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  output logic                rready
);

  state_e              state;
  logic [ADDR_W-1:0]   req_addr;
  logic                setup;
  logic                launch;
  logic [ADDR_W-1:0]   l_addr;
  logic [DATA_W-1:0]   l_wdata;
  logic                l_write;
  logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                wreq_done;

  assign awaddr = req_addr;
  assign araddr = req_addr;
  assign awprot = AXI_PROT;
  assign arprot = AXI_PROT;
  assign wstrb  = '1;

  assign setup = psel && !penable;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  // AW and W retire independently; the write request is finished once neither is still pending.
  assign wreq_done = (awvalid || wvalid) && (!awvalid || awready) && (!wvalid || wready);

`ifdef APB2AXI_TIMEOUT_EN
  logic              expired;
  logic              to_fire;
  logic              axi_idle;
  logic              draining;
  logic              queued;
  logic [ADDR_W-1:0] q_addr;
  logic [DATA_W-1:0] q_wdata;
  logic              q_write;

  assign axi_idle = !(arvalid || rready || awvalid || wvalid || bready);
  // A response landing in the expiry cycle still wins over the timeout.
  assign to_fire  = expired && ((state == AR) || (state == WREQ) ||
                                (state == RD && !r_hs) || (state == WR && !b_hs));

  apb2axi_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (launch),
    .clear   (state == DONE),
    .expired (expired)
  );
`endif

  always_comb begin
    launch  = 1'b0;
    l_addr  = paddr;
    l_wdata = pwdata;
    l_write = pwrite;
    if (state == IDLE) launch = setup;
`ifdef APB2AXI_TIMEOUT_EN
    if (state == DRAIN && axi_idle) begin
      launch = queued || setup;
      if (queued) begin
        l_addr  = q_addr;
        l_wdata = q_wdata;
        l_write = q_write;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_addr <= '0;
      wdata    <= '0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
`ifdef APB2AXI_TIMEOUT_EN
      draining <= 1'b0;
      queued   <= 1'b0;
      q_addr   <= '0;
      q_wdata  <= '0;
      q_write  <= 1'b0;
`endif
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;

      // Channel bookkeeping runs in every state so a drain can finish handshakes on its own.
      if (ar_hs) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (r_hs)      rready  <= 1'b0;
      if (aw_hs)     awvalid <= 1'b0;
      if (w_hs)      wvalid  <= 1'b0;
      if (wreq_done) bready  <= 1'b1;
      if (b_hs)      bready  <= 1'b0;

      case (state)
        AR: if (ar_hs) state <= RD;
        RD: if (r_hs) begin
          prdata  <= rdata;
          pready  <= 1'b1;
          pslverr <= resp_is_err(rresp);
          state   <= DONE;
        end
        WREQ: if (wreq_done) state <= WR;
        WR: if (b_hs) begin
          pready  <= 1'b1;
          pslverr <= resp_is_err(bresp);
          state   <= DONE;
        end
`ifdef APB2AXI_TIMEOUT_EN
        DONE: state <= draining ? DRAIN : IDLE;
        DRAIN: begin
          if (axi_idle) begin
            state    <= IDLE;
            draining <= 1'b0;
            queued   <= 1'b0;
          end else if (setup && !queued) begin
            queued  <= 1'b1;
            q_addr  <= paddr;
            q_wdata <= pwdata;
            q_write <= pwrite;
          end
        end
`else
        DONE: state <= IDLE;
`endif
        default: ;
      endcase

`ifdef APB2AXI_TIMEOUT_EN
      if (to_fire) begin
        state    <= DONE;
        pready   <= 1'b1;
        pslverr  <= 1'b1;
        draining <= 1'b1;
        // Only a timed-out read reports the marker; a write leaves prdata alone.
        if (state == AR || state == RD) prdata <= DATA_W'(TIMEOUT_DATA);
      end
`endif

      if (launch) begin
        req_addr <= l_addr;
        if (l_write) begin
          wdata   <= l_wdata;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          state   <= WREQ;
        end else begin
          arvalid <= 1'b1;
          state   <= AR;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb2axi.sv
// Directed bench for apb2axi: reads, writes, error responses, AR stall, mid-transfer reset,
// and (with APB2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16) timeout followed by drain and a queued read.
module tb_apb2axi;
  import apb2axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb2axi #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] rd, input logic [1:0] rsp,
                         output logic [31:0] got_data, output logic got_err, output int got_lat,
                         output logic [31:0] got_araddr);
    got_data = '0; got_err = 1'b0; got_lat = -1; got_araddr = '0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; arready = 1'b1;
    tick();
    penable = 1'b1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (arvalid) got_araddr = araddr;
      if (pready) begin
        got_lat = cyc; got_data = prdata; got_err = pslverr;
        break;
      end
      rvalid = rready; rdata = rd; rresp = rsp;
      tick();
    end
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0; arready = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] rsp,
                          output logic got_err, output int got_lat);
    got_err = 1'b0; got_lat = -1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
    awready = 1'b1; wready = 1'b1;
    tick();
    penable = 1'b1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (pready) begin
        got_lat = cyc; got_err = pslverr;
        break;
      end
      bvalid = bready; bresp = rsp;
      tick();
    end
    psel = 1'b0; penable = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    tests++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      fails++; $display("FAIL reset_axi: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    tests++; if ({pready, pslverr} !== 2'b00) begin
      fails++; $display("FAIL reset_apb: got %b expected 00", {pready, pslverr});
    end
    tests++; if (prdata !== 32'h0) begin
      fails++; $display("FAIL reset_prdata: got %h expected 00000000", prdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [31:0] d, a; logic e; int l;
    do_read(32'h0000_0010, 32'h1234_5678, RESP_OKAY, d, e, l, a);
    tests++; if (a !== 32'h10) begin fails++; $display("FAIL read_araddr: got %h expected 00000010", a); end
    tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL read_prdata: got %h expected 12345678", d); end
    tests++; if (l !== 3) begin fails++; $display("FAIL read_latency: got %0d expected 3", l); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL read_pslverr: got %b expected 0", e); end
    tests++; if (arprot !== 3'b000) begin fails++; $display("FAIL read_arprot: got %b expected 000", arprot); end
  endtask

  task automatic test_write();
    int aw_n, w_n, b_cyc, rdy_cyc; logic strb_ok, dat_ok, e;
    aw_n = 0; w_n = 0; b_cyc = -1; rdy_cyc = -1; strb_ok = 1'b1; dat_ok = 1'b1; e = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0020; pwdata = 32'hA5A5_0001;
    awready = 1'b1; wready = 1'b0;
    tick();
    penable = 1'b1;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (pready) begin rdy_cyc = cyc; e = pslverr; break; end
      awready = 1'b1;
      wready  = (cyc >= 3);
      bvalid  = bready; bresp = RESP_OKAY;
      if (awvalid && awready) begin aw_n++; if (awaddr !== 32'h20) dat_ok = 1'b0; end
      if (wvalid) begin
        if (wstrb !== 4'hF) strb_ok = 1'b0;
        if (wdata !== 32'hA5A5_0001) dat_ok = 1'b0;
        if (wready) w_n++;
      end
      if (bvalid) b_cyc = cyc;
      tick();
    end
    psel = 1'b0; penable = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    tests++; if (aw_n !== 1) begin fails++; $display("FAIL write_aw_count: got %0d expected 1", aw_n); end
    tests++; if (w_n !== 1) begin fails++; $display("FAIL write_w_count: got %0d expected 1", w_n); end
    tests++; if (strb_ok !== 1'b1) begin fails++; $display("FAIL write_wstrb: got bad strobe expected F"); end
    tests++; if (dat_ok !== 1'b1) begin fails++; $display("FAIL write_addr_data: got bad awaddr/wdata expected 20/A5A50001"); end
    tests++; if (b_cyc !== 4) begin fails++; $display("FAIL write_bvalid_cycle: got %0d expected 4", b_cyc); end
    tests++; if (rdy_cyc !== 5) begin fails++; $display("FAIL write_pready_cycle: got %0d expected 5", rdy_cyc); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL write_pslverr: got %b expected 0", e); end
    tests++; if (prdata !== 32'h1234_5678) begin fails++; $display("FAIL write_prdata_held: got %h expected 12345678", prdata); end
  endtask

  task automatic test_errors();
    logic [31:0] d, a; logic e; int l;
    do_read(32'h0000_0030, 32'h0000_0077, RESP_SLVERR, d, e, l, a);
    tests++; if (e !== 1'b1 || l !== 3) begin fails++; $display("FAIL err_read_slverr: got err=%b lat=%0d expected err=1 lat=3", e, l); end
    do_write(32'h0000_0034, 32'h0000_0099, RESP_DECERR, e, l);
    tests++; if (e !== 1'b1 || l !== 3) begin fails++; $display("FAIL err_write_decerr: got err=%b lat=%0d expected err=1 lat=3", e, l); end
    do_read(32'h0000_0038, 32'h0000_0055, 2'b01, d, e, l, a);
    tests++; if (e !== 1'b0 || d !== 32'h55) begin fails++; $display("FAIL err_read_exokay: got err=%b data=%h expected err=0 data=00000055", e, d); end
  endtask

  task automatic test_ar_stall();
    logic stable, low; int l; logic [31:0] d;
    stable = 1'b1; low = 1'b1; l = -1; d = '0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0040; arready = 1'b0;
    tick();
    penable = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (arvalid !== 1'b1 || araddr !== 32'h40) stable = 1'b0;
      if (pready !== 1'b0) low = 1'b0;
      tick();
    end
    for (int cyc = 11; cyc < 30; cyc++) begin
      if (pready) begin l = cyc; d = prdata; break; end
      arready = 1'b1; rvalid = rready; rdata = 32'h0BAD_F00D; rresp = RESP_OKAY;
      tick();
    end
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0; arready = 1'b0;
    tick();
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL stall_ar_stable: got unstable arvalid/araddr expected 1/00000040"); end
    tests++; if (low !== 1'b1) begin fails++; $display("FAIL stall_pready_low: got pready=1 expected 0"); end
    tests++; if (l !== 13) begin fails++; $display("FAIL stall_latency: got %0d expected 13", l); end
    tests++; if (d !== 32'h0BAD_F00D) begin fails++; $display("FAIL stall_prdata: got %h expected 0badf00d", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, a; logic e; int l; logic was_rd;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0050; arready = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    arready = 1'b0;
    was_rd = rready;
    rst_n = 1'b0;
    #1;
    tests++; if (was_rd !== 1'b1) begin fails++; $display("FAIL rstmid_in_rd: got rready=%b expected 1", was_rd); end
    tests++; if ({arvalid, awvalid, wvalid, rready, bready, pready, pslverr} !== 7'b0) begin
      fails++; $display("FAIL rstmid_ctrl: got %b expected 0000000", {arvalid, awvalid, wvalid, rready, bready, pready, pslverr});
    end
    tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL rstmid_prdata: got %h expected 00000000", prdata); end
    psel = 1'b0; penable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_read(32'h0000_0054, 32'h600D_CAFE, RESP_OKAY, d, e, l, a);
    tests++; if (d !== 32'h600D_CAFE || a !== 32'h54) begin fails++; $display("FAIL rstmid_next_read: got data=%h addr=%h expected 600dcafe/00000054", d, a); end
    tests++; if (l !== 3 || e !== 1'b0) begin fails++; $display("FAIL rstmid_next_lat: got lat=%0d err=%b expected 3/0", l, e); end
  endtask

`ifdef APB2AXI_TIMEOUT_EN
  task automatic test_timeout();
    int first, second; logic e1, e2; logic [31:0] d1, d2, a2;
    first = -1; second = -1; e1 = 1'b0; e2 = 1'b1; d1 = '0; d2 = '0; a2 = '0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0060; arready = 1'b1;
    tick();
    penable = 1'b1;
    for (int cyc = 1; cyc < 80; cyc++) begin
      if (pready) begin
        if (first < 0) begin first = cyc; e1 = pslverr; d1 = prdata; end
        else begin second = cyc; e2 = pslverr; d2 = prdata; break; end
      end
      if (arvalid && arready && cyc > 17) a2 = araddr;
      penable = (cyc != 17);
      if (cyc == 17) paddr = 32'h0000_0044;
      rvalid = (cyc == 40) || (cyc > 40 && rready);
      rdata  = (cyc == 40) ? 32'hBAD0_BAD0 : 32'hCAFE_0002;
      rresp  = RESP_OKAY;
      tick();
    end
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0; arready = 1'b0;
    tick();
    tests++; if (first !== 16 || e1 !== 1'b1) begin fails++; $display("FAIL timeout_pready: got cyc=%0d err=%b expected 16/1", first, e1); end
    tests++; if (d1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL timeout_prdata: got %h expected deadbeef", d1); end
    tests++; if (second !== 44 || e2 !== 1'b0) begin fails++; $display("FAIL drain_queued_pready: got cyc=%0d err=%b expected 44/0", second, e2); end
    tests++; if (d2 !== 32'hCAFE_0002 || a2 !== 32'h44) begin fails++; $display("FAIL drain_queued_data: got %h addr %h expected cafe0002/00000044", d2, a2); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_ar_stall();
    test_reset_mid();
`ifdef APB2AXI_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
